// File: rtl/key_fetch_ctrl.sv
// Fetches an allow-listed key word from the key store for the crypto consumer; key_valid 3 cycles after the request (1-cycle store).
// Requests stall (req_ready=0) until the key is taken or an error pulses; define KEY_ZEROIZE_EN to wipe the key after hand-off.
module key_fetch_ctrl #(
  parameter int                 WIDTH      = 256,
  parameter int                 LENGTH     = 16,
  parameter logic [LENGTH-1:0]  ALLOW_MASK = 16'h3C04,
  parameter int                 TIMEOUT    = 8,
  localparam int                AW         = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rdData,
  input  logic             mem_rdData_valid,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [WIDTH-1:0] key_data,
  output logic             err_valid,
  output logic [1:0]       err_code
);

  localparam int             CW     = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    LEN_W  = (AW + 1)'(LENGTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_key;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_err_code;
  logic             w_in_range;
  logic             w_allowed;
  logic             w_timeout;

  // Addresses past the end of the store are denied even if the mask index aliases.
  assign w_in_range = ({1'b0, req_addr} < LEN_W);
  assign w_allowed  = w_in_range && ALLOW_MASK[req_addr];
  assign w_timeout  = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_rd_en   = 1'b0;
    key_valid   = 1'b0;
    err_valid   = 1'b0;
    err_code    = 2'b00;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = w_allowed ? S_READ : S_ERR;
        end
      end
      S_READ: begin
        mem_rd_en   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rdData_valid) begin
          w_state_nxt = S_HOLD;
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end
      end
      S_HOLD: begin
        key_valid = 1'b1;
        if (key_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        err_valid   = 1'b1;
        err_code    = r_err_code;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_key      <= '0;
      r_cnt      <= '0;
      r_err_code <= 2'b00;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_addr     <= req_addr;
        r_err_code <= w_allowed ? 2'b00 : 2'b01;
      end

      // Counter runs only while waiting so each fetch starts its timeout window from zero.
      if (r_state == S_WAIT && !mem_rdData_valid) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end

      if (r_state == S_WAIT && mem_rdData_valid) begin
        r_key <= mem_rdData;
      end
      if (r_state == S_WAIT && !mem_rdData_valid && w_timeout) begin
        r_err_code <= 2'b10;
      end

`ifdef KEY_ZEROIZE_EN
      if (r_state == S_HOLD && key_ready) begin
        r_key <= '0;
      end
`endif
    end
  end

  assign mem_addr = r_addr;
  assign key_data = r_key;

endmodule
